// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLen0,
        StLen1,
        StData,
        StCsum,
        StDone,
        StErr
    } state_e;

    localparam logic [7:0]  MagicDefault = 8'hA5;
    localparam int unsigned LenW         = 16;

endpackage

// File: rtl/imem_word_packer.sv
// Assembles little-endian 32-bit words from a byte stream and keeps a running XOR.
module imem_word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word,
    output logic [7:0]  csum
);

    logic [1:0]  lane_q;
    logic [23:0] shift_q;
    logic [7:0]  csum_q;

    // Combinational pulse on the 4th byte; the loader registers the write.
    assign word_valid = byte_valid && (lane_q == 2'd3);
    assign word       = {byte_data, shift_q};
    assign csum       = csum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q  <= 2'd0;
            shift_q <= 24'd0;
            csum_q  <= 8'd0;
        end else if (clear) begin
            lane_q  <= 2'd0;
            csum_q  <= 8'd0;
        end else if (byte_valid) begin
            lane_q  <= lane_q + 2'd1;
            shift_q <= {byte_data, shift_q[23:8]};
            csum_q  <= csum_q ^ byte_data;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a framed, XOR-checked image into instruction RAM and holds the core in reset meanwhile.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [7:0]  MAGIC     = MagicDefault
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [7:0]      in_data,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            reload,
    output logic            imem_we,
    output logic [31:0]     imem_waddr,
    output logic [31:0]     imem_wdata,
    output logic            core_rst,
    output logic            done,
    output logic            err,
    output logic [LenW-1:0] words_loaded
);

    state_e          state_q;
    logic [7:0]      len_lo_q;
    logic [LenW-1:0] len_q;

    logic            fire;
    logic [LenW-1:0] len_next;
    logic            len_too_big;
    logic            last_word;
    logic            pk_word_valid;
    logic [31:0]     pk_word;
    logic [7:0]      pk_csum;

    assign fire        = in_valid && in_ready;
    assign len_next    = {in_data, len_lo_q};
    assign len_too_big = 32'(len_next) > (32'd1 << ADDR_W);
    assign last_word   = (words_loaded + 16'd1) == len_q;

    imem_word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (fire && (state_q == StLen1)),
        .byte_valid (fire && (state_q == StData)),
        .byte_data  (in_data),
        .word_valid (pk_word_valid),
        .word       (pk_word),
        .csum       (pk_csum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            len_lo_q     <= 8'd0;
            len_q        <= '0;
            in_ready     <= 1'b0;
            imem_we      <= 1'b0;
            imem_waddr   <= BASE_ADDR;
            imem_wdata   <= 32'd0;
            core_rst     <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
        end else begin
            imem_we <= 1'b0;
            if (pk_word_valid) begin
                imem_we      <= 1'b1;
                imem_waddr   <= BASE_ADDR + (32'(words_loaded) << 2);
                imem_wdata   <= pk_word;
                words_loaded <= words_loaded + 16'd1;
            end
            unique case (state_q)
                StIdle: begin
                    in_ready <= 1'b1;
                    if (fire && (in_data == MAGIC)) state_q <= StLen0;
                end
                StLen0: begin
                    if (fire) begin
                        len_lo_q <= in_data;
                        state_q  <= StLen1;
                    end
                end
                StLen1: begin
                    if (fire) begin
                        len_q        <= len_next;
                        words_loaded <= '0;
                        if (len_too_big) begin
                            state_q  <= StErr;
                            err      <= 1'b1;
                            in_ready <= 1'b0;
                        end else if (len_next == '0) begin
                            state_q <= StCsum;
                        end else begin
                            state_q <= StData;
                        end
                    end
                end
                StData: begin
                    if (pk_word_valid && last_word) state_q <= StCsum;
                end
                StCsum: begin
                    if (fire) begin
                        in_ready <= 1'b0;
                        if (in_data == pk_csum) begin
                            state_q  <= StDone;
                            done     <= 1'b1;
                            core_rst <= 1'b0;
                        end else begin
                            state_q <= StErr;
                            err     <= 1'b1;
                        end
                    end
                end
                StDone, StErr: begin
                    if (reload) begin
                        state_q      <= StIdle;
                        in_ready     <= 1'b1;
                        core_rst     <= 1'b1;
                        done         <= 1'b0;
                        err          <= 1'b0;
                        words_loaded <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framing, checksum, length limits, backpressure, reload, reset.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        reload = 1'b0;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        done;
    logic        err;
    logic [15:0] words_loaded;

    imem_loader #(
        .ADDR_W    (10),
        .BASE_ADDR (32'h0000_0000),
        .MAGIC     (8'hA5)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .reload       (reload),
        .imem_we      (imem_we),
        .imem_waddr   (imem_waddr),
        .imem_wdata   (imem_wdata),
        .core_rst     (core_rst),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int hs_cyc[$];
    int wr_cyc[$];
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (imem_we) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(imem_waddr);
            wr_data.push_back(imem_wdata);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: run did not finish");
        $fatal(1, "timeout");
    end

    task automatic clear_logs();
        hs_cyc.delete();
        wr_cyc.delete();
        wr_addr.delete();
        wr_data.delete();
    endtask

    // Entered and left on a falling edge; records the cycle of each accepted byte.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t = 0;
        repeat (gap) @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) begin
            total++;
            bad++;
            $display("FAIL handshake_timeout: byte %h not accepted, in_ready=%b want 1", b, in_ready);
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        hs_cyc.push_back(cyc);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] f[$], input int max_gap);
        foreach (f[i]) send_byte(f[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    endtask

    task automatic build_frame(input logic [31:0] w[$], input logic [7:0] flip,
                               output logic [7:0] f[$]);
        logic [7:0]  x = 8'h00;
        logic [15:0] n = 16'(w.size());
        f = {};
        f.push_back(8'hA5);
        f.push_back(n[7:0]);
        f.push_back(n[15:8]);
        foreach (w[i]) begin
            for (int k = 0; k < 4; k++) begin
                f.push_back(w[i][8*k +: 8]);
                x ^= w[i][8*k +: 8];
            end
        end
        f.push_back(x ^ flip);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({in_ready, imem_we, imem_waddr, imem_wdata, core_rst, done, err, words_loaded}
            !== {1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 16'h0}) begin
            bad++;
            $display("FAIL reset_values: rdy=%b we=%b a=%h d=%h crst=%b done=%b err=%b wl=%0d",
                     in_ready, imem_we, imem_waddr, imem_wdata, core_rst, done, err, words_loaded);
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL ready_before_clock: got %b want 0", in_ready);
        end
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_clock: got %b want 1", in_ready);
        end
    endtask

    // Data bytes 13 00 00 00 93 00 10 00 XOR to 0x90.
    task automatic test_normal();
        logic [7:0] f[$] = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                             8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        clear_logs();
        send_frame(f, 0);
        total++;
        if (wr_data.size() != 2 || hs_cyc.size() != 12) begin
            bad++;
            $display("FAIL normal_count: writes=%0d want 2, bytes=%0d want 12",
                     wr_data.size(), hs_cyc.size());
        end else begin
            total++;
            if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h0000_0013 || wr_cyc[0] != hs_cyc[6]) begin
                bad++;
                $display("FAIL normal_w0: a=%h d=%h c=%0d want 0/00000013/%0d",
                         wr_addr[0], wr_data[0], wr_cyc[0], hs_cyc[6]);
            end
            total++;
            if (wr_addr[1] !== 32'h4 || wr_data[1] !== 32'h0010_0093 || wr_cyc[1] != hs_cyc[10]) begin
                bad++;
                $display("FAIL normal_w1: a=%h d=%h c=%0d want 4/00100093/%0d",
                         wr_addr[1], wr_data[1], wr_cyc[1], hs_cyc[10]);
            end
        end
        total++;
        if ({done, core_rst, err, in_ready, words_loaded} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'd2}) begin
            bad++;
            $display("FAIL normal_done: done=%b crst=%b err=%b rdy=%b wl=%0d want 1 0 0 0 2",
                     done, core_rst, err, in_ready, words_loaded);
        end
        total++;
        if (imem_wdata !== 32'h0010_0093 || imem_waddr !== 32'h4) begin
            bad++;
            $display("FAIL normal_hold: a=%h d=%h want 4/00100093", imem_waddr, imem_wdata);
        end
    endtask

    // Image 0xDEADBEEF: bytes EF BE AD DE XOR to 0x22.
    task automatic test_reload_done();
        logic [7:0] f[$] = '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
        in_data  = 8'h55;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b0 || done !== 1'b1) begin
            bad++;
            $display("FAIL done_blocks: rdy=%b done=%b want 0 1", in_ready, done);
        end
        pulse_reload();
        total++;
        if ({core_rst, done, err, words_loaded, in_ready} !== {1'b1, 1'b0, 1'b0, 16'd0, 1'b1}) begin
            bad++;
            $display("FAIL reload_done: crst=%b done=%b err=%b wl=%0d rdy=%b want 1 0 0 0 1",
                     core_rst, done, err, words_loaded, in_ready);
        end
        clear_logs();
        send_frame(f, 0);
        total++;
        if (wr_data.size() != 1 || done !== 1'b1 || core_rst !== 1'b0) begin
            bad++;
            $display("FAIL second_image: writes=%0d done=%b crst=%b want 1 1 0",
                     wr_data.size(), done, core_rst);
        end else begin
            total++;
            if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'hDEAD_BEEF) begin
                bad++;
                $display("FAIL second_image_w0: a=%h d=%h want 0/deadbeef", wr_addr[0], wr_data[0]);
            end
        end
        pulse_reload();
    endtask

    task automatic test_junk();
        logic [7:0] f[$] = '{8'h00, 8'hFF, 8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                             8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        clear_logs();
        send_frame(f, 0);
        total++;
        if (hs_cyc.size() != 14 || wr_data.size() != 2) begin
            bad++;
            $display("FAIL junk_count: bytes=%0d want 14, writes=%0d want 2",
                     hs_cyc.size(), wr_data.size());
        end else begin
            total++;
            if (wr_data[0] !== 32'h0000_0013 || wr_data[1] !== 32'h0010_0093 ||
                wr_addr[1] !== 32'h4) begin
                bad++;
                $display("FAIL junk_words: d0=%h d1=%h a1=%h want 00000013 00100093 4",
                         wr_data[0], wr_data[1], wr_addr[1]);
            end
        end
        total++;
        if (done !== 1'b1 || core_rst !== 1'b0) begin
            bad++;
            $display("FAIL junk_done: done=%b crst=%b want 1 0", done, core_rst);
        end
        pulse_reload();
    endtask

    task automatic test_bad_csum();
        logic [7:0] f[$] = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                             8'h93, 8'h00, 8'h10, 8'h00, 8'h81};
        clear_logs();
        send_frame(f, 0);
        total++;
        if ({wr_data.size() == 2, err, done, core_rst, in_ready}
            !== {1'b1, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL bad_csum: writes=%0d err=%b done=%b crst=%b rdy=%b want 2 1 0 1 0",
                     wr_data.size(), err, done, core_rst, in_ready);
        end
        pulse_reload();
        total++;
        if (err !== 1'b0 || core_rst !== 1'b1) begin
            bad++;
            $display("FAIL reload_err: err=%b crst=%b want 0 1", err, core_rst);
        end
    endtask

    task automatic test_len_overflow();
        logic [7:0] f[$] = '{8'hA5, 8'h01, 8'h04};
        clear_logs();
        send_frame(f, 0);
        total++;
        if ({err, done, core_rst, in_ready} !== 4'b1010 || wr_data.size() != 0) begin
            bad++;
            $display("FAIL len_0401: err=%b done=%b crst=%b rdy=%b writes=%0d want 1 0 1 0 0",
                     err, done, core_rst, in_ready, wr_data.size());
        end
        pulse_reload();
    endtask

    task automatic test_len_max();
        logic [31:0] w[$];
        logic [7:0]  f[$];
        int          n;
        for (int i = 0; i < 1024; i++) w.push_back({16'(i) ^ 16'hC3A5, 16'(i)});
        build_frame(w, 8'h00, f);
        clear_logs();
        send_frame(f, 0);
        n = wr_data.size();
        total++;
        if (n != 1024) begin
            bad++;
            $display("FAIL len_0400_count: got %0d want 1024", n);
        end else begin
            total++;
            if (wr_addr[1023] !== 32'hFFC || wr_data[1023] !== w[1023]) begin
                bad++;
                $display("FAIL len_0400_last: a=%h d=%h want ffc/%h",
                         wr_addr[1023], wr_data[1023], w[1023]);
            end
        end
        total++;
        if (done !== 1'b1 || words_loaded !== 16'd1024) begin
            bad++;
            $display("FAIL len_0400_done: done=%b wl=%0d want 1 1024", done, words_loaded);
        end
        pulse_reload();
    endtask

    task automatic test_len_zero();
        logic [7:0] f[$] = '{8'hA5, 8'h00, 8'h00, 8'h00};
        clear_logs();
        send_frame(f, 0);
        total++;
        if ({done, core_rst, err} !== 3'b100 || wr_data.size() != 0 || words_loaded !== 16'd0) begin
            bad++;
            $display("FAIL len_zero: done=%b crst=%b err=%b writes=%0d wl=%0d want 1 0 0 0 0",
                     done, core_rst, err, wr_data.size(), words_loaded);
        end
        pulse_reload();
    endtask

    task automatic test_backpressure();
        logic [31:0] w[$] = '{32'h1122_3344, 32'hA0B0_C0D0, 32'h0000_00FF,
                              32'hFFFF_0000, 32'h8765_4321};
        logic [7:0]  f[$];
        build_frame(w, 8'h00, f);
        clear_logs();
        send_frame(f, 3);
        total++;
        if (wr_data.size() != w.size() || hs_cyc.size() != f.size()) begin
            bad++;
            $display("FAIL bp_count: writes=%0d want %0d, bytes=%0d want %0d",
                     wr_data.size(), w.size(), hs_cyc.size(), f.size());
        end else begin
            for (int i = 0; i < w.size(); i++) begin
                total++;
                if (wr_addr[i] !== 32'(4 * i) || wr_data[i] !== w[i] || wr_cyc[i] != hs_cyc[6+4*i]) begin
                    bad++;
                    $display("FAIL bp_word%0d: a=%h d=%h c=%0d want %h/%h/%0d", i, wr_addr[i],
                             wr_data[i], wr_cyc[i], 32'(4 * i), w[i], hs_cyc[6+4*i]);
                end
            end
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL bp_done: got %b want 1", done);
        end
        pulse_reload();
    endtask

    task automatic test_reload_in_data();
        logic [7:0] a[$] = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56};
        logic [7:0] b[$] = '{8'h34, 8'h12, 8'h08};
        clear_logs();
        send_frame(a, 0);
        pulse_reload();
        send_frame(b, 0);
        total++;
        if (wr_data.size() != 1 || done !== 1'b1 || words_loaded !== 16'd1) begin
            bad++;
            $display("FAIL reload_in_data: writes=%0d done=%b wl=%0d want 1 1 1",
                     wr_data.size(), done, words_loaded);
        end else begin
            total++;
            if (wr_data[0] !== 32'h1234_5678) begin
                bad++;
                $display("FAIL reload_in_data_w0: got %h want 12345678", wr_data[0]);
            end
        end
        pulse_reload();
    endtask

    task automatic test_reset_mid_data();
        logic [7:0] f[$] = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00};
        clear_logs();
        send_frame(f, 0);
        total++;
        if (words_loaded !== 16'd1 || imem_wdata !== 32'h13) begin
            bad++;
            $display("FAIL pre_reset_state: wl=%0d d=%h want 1 00000013", words_loaded, imem_wdata);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({in_ready, imem_we, imem_waddr, imem_wdata, core_rst, done, err, words_loaded}
            !== {1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 16'h0}) begin
            bad++;
            $display("FAIL async_reset: rdy=%b we=%b a=%h d=%h crst=%b done=%b err=%b wl=%0d",
                     in_ready, imem_we, imem_waddr, imem_wdata, core_rst, done, err, words_loaded);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || core_rst !== 1'b1) begin
            bad++;
            $display("FAIL after_reset: rdy=%b crst=%b want 1 1", in_ready, core_rst);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_reload_done();
        test_junk();
        test_bad_csum();
        test_len_overflow();
        test_len_max();
        test_len_zero();
        test_backpressure();
        test_reload_in_data();
        test_reset_mid_data();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
